// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with occupancy flags, sticky error flags,
// flush, and a choice of registered-read or first-word-fall-through output.
module param_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 256,
    parameter int AF_LEVEL   = FIFO_DEPTH - 4,
    parameter int AE_LEVEL   = 4,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic                          clear_err,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     r_wrPtr;
    logic [ADDR_W-1:0]     r_rdPtr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_popOk;
    logic w_wrOk;
    logic w_ovfEvent;
    logic w_unfEvent;

    // Flush masks every request so an ignored push/pop neither moves state
    // nor raises an error. A pop on a full FIFO frees a slot for the push.
    assign w_popOk    = pop & ~empty & ~flush;
    assign w_wrOk     = push & (~full | w_popOk) & ~flush;
    assign w_ovfEvent = push & full & ~pop & ~flush;
    assign w_unfEvent = pop & empty & ~flush;

    // Occupancy flags come straight from the registered count.
    assign full         = (r_count == DEPTH_CNT);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= AF_CNT);
    assign almost_empty = (r_count <= AE_CNT);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Pointer and count bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_wrOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_popOk) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_wrOk, w_popOk})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array is never reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (!rst && w_wrOk) begin
            r_mem[r_wrPtr] <= data_in;
        end
    end

    // Sticky error flags: a new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovfEvent | (r_overflow & ~clear_err);
            r_underflow <= w_unfEvent | (r_underflow & ~clear_err);
        end
    end

    generate
        if (FWFT == 0) begin : g_regRead
            logic [DATA_WIDTH-1:0] r_dataOut;
            logic                  r_valid;

            // Registered read: capture the head on a successful pop, valid for one cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dataOut <= '0;
                    r_valid   <= 1'b0;
                end else begin
                    r_valid <= w_popOk;
                    if (w_popOk) begin
                        r_dataOut <= r_mem[r_rdPtr];
                    end
                end
            end

            assign data_out = r_dataOut;
            assign valid    = r_valid;
        end else begin : g_fwft
            // Head entry is always presented; gated to zero when nothing is stored.
            assign valid    = ~empty;
            assign data_out = valid ? r_mem[r_rdPtr] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: one registered-read and one FWFT instance
// share the same stimulus and are compared against a queue-based model.
module tb_param_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic [DW-1:0] dataIn;
    logic          push;
    logic          pop;
    logic          flush;
    logic          clearErr;

    logic [DW-1:0] dataOutR, dataOutF;
    logic          validR, validF;
    logic          fullR, fullF, emptyR, emptyF;
    logic          afR, afF, aeR, aeF;
    logic [CW-1:0] countR, countF;
    logic          ovfR, ovfF, unfR, unfF;

    int total;
    int bad;

    // Reference model state
    logic [DW-1:0] mq[$];
    bit            mOvf;
    bit            mUnf;
    logic [DW-1:0] mDout;
    bit            mValid;
    bit            checkEn;

    param_fifo #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)
    ) u_dutReg (
        .clk(clk), .rst(rst), .data_in(dataIn), .push(push), .pop(pop),
        .flush(flush), .clear_err(clearErr), .data_out(dataOutR), .valid(validR),
        .full(fullR), .empty(emptyR), .almost_full(afR), .almost_empty(aeR),
        .count(countR), .overflow(ovfR), .underflow(unfR)
    );

    param_fifo #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)
    ) u_dutFwft (
        .clk(clk), .rst(rst), .data_in(dataIn), .push(push), .pop(pop),
        .flush(flush), .clear_err(clearErr), .data_out(dataOutF), .valid(validF),
        .full(fullF), .empty(emptyF), .almost_full(afF), .almost_empty(aeF),
        .count(countF), .overflow(ovfF), .underflow(unfF)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of stored words updated on each rising edge.
    always @(posedge clk) begin : modelUpdate
        int  sz;
        bit  popOk;
        bit  wrOk;
        sz = mq.size();
        if (rst) begin
            mq.delete();
            mOvf    = 1'b0;
            mUnf    = 1'b0;
            mDout   = '0;
            mValid  = 1'b0;
            checkEn = 1'b1;
        end else if (flush) begin
            mq.delete();
            mValid = 1'b0;
        end else begin
            popOk = pop && (sz > 0);
            wrOk  = push && ((sz < DEPTH) || popOk);
            if (clearErr) begin
                mOvf = 1'b0;
                mUnf = 1'b0;
            end
            if (push && (sz == DEPTH) && !pop) mOvf = 1'b1;
            if (pop && (sz == 0)) mUnf = 1'b1;
            mValid = popOk;
            if (popOk) mDout = mq.pop_front();
            if (wrOk) mq.push_back(dataIn);
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin : compare
        int sz;
        if (checkEn) begin
            sz = mq.size();
            checkOutput("countR", int'(countR), sz);
            checkOutput("countF", int'(countF), sz);
            checkOutput("fullR", int'(fullR), int'(sz == DEPTH));
            checkOutput("fullF", int'(fullF), int'(sz == DEPTH));
            checkOutput("emptyR", int'(emptyR), int'(sz == 0));
            checkOutput("emptyF", int'(emptyF), int'(sz == 0));
            checkOutput("afR", int'(afR), int'(sz >= 6));
            checkOutput("afF", int'(afF), int'(sz >= 6));
            checkOutput("aeR", int'(aeR), int'(sz <= 2));
            checkOutput("aeF", int'(aeF), int'(sz <= 2));
            checkOutput("ovfR", int'(ovfR), int'(mOvf));
            checkOutput("ovfF", int'(ovfF), int'(mOvf));
            checkOutput("unfR", int'(unfR), int'(mUnf));
            checkOutput("unfF", int'(unfF), int'(mUnf));
            checkOutput("validR", int'(validR), int'(mValid));
            checkOutput("dataR", int'(dataOutR), int'(mDout));
            checkOutput("validF", int'(validF), int'(sz > 0));
            checkOutput("dataF", int'(dataOutF), (sz > 0) ? int'(mq[0]) : 0);
        end
    end

    // Drive one cycle of requests, then wait until just after the edge.
    task automatic applyStimulus(input bit p, input bit q, input bit f, input bit c,
                                 input logic [DW-1:0] d);
        push     = p;
        pop      = q;
        flush    = f;
        clearErr = c;
        dataIn   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] expWord;
        int pushPct;
        int popPct;
        bit doFlush;

        total    = 0;
        bad      = 0;
        checkEn  = 1'b0;
        rst      = 1'b1;
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        clearErr = 1'b0;
        dataIn   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        checkOutput("rstEmpty", int'(emptyR), 1);
        checkOutput("rstFull", int'(fullR), 0);
        checkOutput("rstAe", int'(aeR), 1);
        checkOutput("rstAf", int'(afR), 0);
        checkOutput("rstCount", int'(countR), 0);
        checkOutput("rstValidR", int'(validR), 0);
        checkOutput("rstDataR", int'(dataOutR), 0);
        checkOutput("rstValidF", int'(validF), 0);

        // Fill with 0x11..0x18, then drain in order
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 0, 0, DW'(8'h11 + i));
        end
        checkOutput("fillFull", int'(fullR), 1);
        checkOutput("fillCount", int'(countR), 8);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 0, 0, '0);
            expWord = DW'(8'h11 + i);
            checkOutput("drainData", int'(dataOutR), int'(expWord));
            checkOutput("drainValid", int'(validR), 1);
        end
        applyStimulus(0, 0, 0, 0, '0);
        checkOutput("drainIdleValid", int'(validR), 0);
        checkOutput("drainEmpty", int'(emptyR), 1);

        // Overflow drops the word; clear_err clears the flag
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 0, 0, DW'(8'h21 + i));
        end
        applyStimulus(1, 0, 0, 0, 8'hAA);
        checkOutput("ovfSet", int'(ovfR), 1);
        checkOutput("ovfCount", int'(countR), 8);
        applyStimulus(0, 0, 0, 1, '0);
        checkOutput("ovfClr", int'(ovfR), 0);

        // Simultaneous push and pop while full
        applyStimulus(1, 1, 0, 0, 8'h55);
        checkOutput("fullPpCount", int'(countR), 8);
        checkOutput("fullPpHead", int'(dataOutR), 8'h21);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 0, 0, '0);
            expWord = (i < 7) ? DW'(8'h22 + i) : 8'h55;
            checkOutput("fullPpData", int'(dataOutR), int'(expWord));
        end

        // Simultaneous push and pop while empty
        applyStimulus(1, 1, 0, 0, 8'h3C);
        checkOutput("emptyPpCount", int'(countR), 1);
        checkOutput("emptyPpUnf", int'(unfR), 1);
        applyStimulus(0, 1, 0, 0, '0);
        checkOutput("emptyPpData", int'(dataOutR), 8'h3C);
        applyStimulus(0, 0, 0, 1, '0);

        // First-word-fall-through visibility
        applyStimulus(1, 0, 0, 0, 8'h01);
        checkOutput("fwftValid", int'(validF), 1);
        checkOutput("fwftFirst", int'(dataOutF), 8'h01);
        applyStimulus(1, 0, 0, 0, 8'h02);
        applyStimulus(0, 1, 0, 0, '0);
        checkOutput("fwftSecond", int'(dataOutF), 8'h02);
        applyStimulus(0, 1, 0, 0, '0);
        applyStimulus(0, 0, 0, 0, '0);

        // Randomised traffic with phases biased toward full and toward empty
        for (int i = 0; i < 600; i++) begin
            pushPct = ((i / 50) % 2 == 0) ? 75 : 30;
            popPct  = 100 - pushPct;
            doFlush = ($urandom_range(0, 59) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            applyStimulus($urandom_range(0, 99) < pushPct,
                          $urandom_range(0, 99) < popPct,
                          doFlush,
                          !doFlush && ($urandom_range(0, 19) == 0),
                          DW'($urandom));
        end
        rst = 1'b0;

        // Wrap traffic, then flush with a push pending and an error flag set
        applyStimulus(0, 0, 1, 0, '0);
        applyStimulus(0, 0, 0, 1, '0);
        applyStimulus(0, 1, 0, 0, '0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, DW'(8'h40 + i));
        end
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, 1, 0, 0, DW'(8'h50 + i));
        end
        checkOutput("wrapCount", int'(countR), 5);
        applyStimulus(1, 0, 1, 0, 8'hEE);
        checkOutput("flushCount", int'(countR), 0);
        checkOutput("flushEmpty", int'(emptyR), 1);
        checkOutput("flushUnf", int'(unfR), 1);
        checkOutput("flushOvf", int'(ovfR), 0);
        applyStimulus(0, 0, 0, 0, '0);
        checkOutput("flushNoWrite", int'(countF), 0);
        applyStimulus(0, 0, 0, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
